regfile_scan_reader: RTL and testbench
======================================

Name: regfile_scan_reader

Overview:
- Read-side sequencer for the 16x32 register bank.
- Walks a block of consecutive register addresses through the bank's single read port.
- Streams each word out on a valid/ready interface, tagged with its address and an end-of-burst flag.
- Sits between the register bank and any downstream consumer (debug dump, serializer, DMA), complementing the write_en/add_line write path.

Parameters:
- DATA_W, 32, width of one register word
- ADDR_W, 4, register address width; bank depth = 2**ADDR_W = 16

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE
- start_addr  input  ADDR_W  first register address of burst
- count  input  ADDR_W+1  words in burst; 0 means 16, values >16 saturate to 16
- abort  input  1  synchronous cancel of current burst
- rd_en  output  1  read strobe to register bank
- rd_addr  output  ADDR_W  read address to register bank
- rd_data  input  DATA_W  bank read data, valid exactly one cycle after rd_en
- out_data  output  DATA_W  streamed word
- out_addr  output  ADDR_W  address the word was read from
- out_last  output  1  high with final word of burst
- out_valid  output  1  out_data/out_addr/out_last valid
- out_ready  input  1  consumer accepts word when out_valid && out_ready
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after last word accepted or abort

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, all outputs 0 (rd_en, rd_addr, out_data, out_addr, out_last, out_valid, busy, done); internal address and remaining-count registers 0.
- FSM states: IDLE, ISSUE, CAPT, SEND, DONE.
- IDLE:
  - start=1 latches start_addr into cur_addr and effective count into remaining.
  - Effective count: count==0 or count>16 gives 16.
  - Next state ISSUE. start=0 stays in IDLE.
- ISSUE: rd_en=1, rd_addr=cur_addr for exactly one cycle; -> CAPT.
- CAPT:
  - rd_en=0; at end of cycle rd_data is registered into out_data, cur_addr into out_addr.
  - out_last set if remaining==1.
  - -> SEND.
- SEND:
  - out_valid=1; data, addr and last held stable until handshake.
  - On out_valid&&out_ready: out_valid drops next cycle, remaining decrements, cur_addr increments modulo 16 (15 wraps to 0).
  - Then -> DONE if that word was last, else -> ISSUE.
- DONE: done=1 for one cycle, busy stays 1; -> IDLE.
- Latency:
  - start at edge T gives rd_en high in cycle T+1 and out_valid high from cycle T+3.
  - With out_ready tied high: one word per 3 cycles; done pulses the cycle after the last handshake.
- busy=1 from the cycle after start is accepted through the DONE cycle. start is ignored whenever busy=1, and stays ignored even if it is held.
- abort:
  - In ISSUE, CAPT or SEND, abort forces the next state to DONE. out_valid drops next cycle without a handshake; this is the only case valid may drop before ready.
  - No further rd_en is issued. done pulses once.
  - abort is ignored in IDLE and DONE.
- abort and handshake in the same SEND cycle: the word counts as delivered; go to DONE.
- out_data, out_addr and out_last hold their last value after the burst; only out_valid qualifies them.
- Reset asserted mid-burst returns immediately to IDLE with the reset values above; no done pulse.
- rd_data is only sampled in CAPT; it is don't-care otherwise.

Test Plan:
- Reset then start, start_addr=0, count=4, out_ready=1, bank reg[i]=32'hA000_0000+i -> 4 words A0000000..A0000003 with out_addr 0..3, out_last only on addr 3, rd_en pulses at T+1, T+4, T+7, T+10, single done pulse, busy back to 0.
- start_addr=14, count=4 -> out_addr sequence 14, 15, 0, 1 (wrap), matching data, out_last on addr 1.
- count=0 and separately count=20 -> exactly 16 words each, starting at start_addr, out_last on 16th.
- out_ready held 0 for 5 cycles on word 2 of a 3-word burst -> out_valid/out_data/out_addr stable throughout, no extra rd_en, burst completes after ready rises.
- abort during SEND of word 1 of 8 (no ready) -> out_valid low next cycle, done one pulse, no further rd_en; re-pulse start during busy is ignored, start after idle runs normally.
- reset_n low asynchronously mid-CAPT -> all outputs 0 immediately, state IDLE, no done; a subsequent start runs a clean burst.

Source files
------------

// File: rtl/regfile_scan_reader.sv
// Read-side sequencer for the register bank: walks a block of consecutive
// addresses through the single read port and streams words out on valid/ready.
module regfile_scan_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPT, SEND, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   eff_count;
  logic              hs;

  // zero or oversize requests mean a full sweep of the bank
  assign eff_count = (count == '0 || count > DEPTH) ? DEPTH : count;
  assign hs        = (state == SEND) && out_ready;
  assign rd_addr   = cur_addr;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        rd_en     = 1'b1;
        state_nxt = CAPT;
      end
      CAPT: state_nxt = SEND;
      SEND: begin
        out_valid = 1'b1;
        if (hs) state_nxt = out_last ? DONE : ISSUE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // abort wins over everything; a same-cycle handshake still counts below
    if (abort && (state == ISSUE || state == CAPT || state == SEND))
      state_nxt = DONE;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cur_addr  <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        cur_addr  <= start_addr;
        remaining <= eff_count;
      end
      if (state == CAPT) begin
        out_data <= rd_data;
        out_addr <= cur_addr;
        out_last <= (remaining == (ADDR_W+1)'(1));
      end
      if (hs) begin
        remaining <= remaining - (ADDR_W+1)'(1);
        cur_addr  <= cur_addr + ADDR_W'(1);
      end
    end
endmodule

// File: tb/tb_regfile_scan_reader.sv
// Directed bench for regfile_scan_reader: table of full-rate bursts plus
// hand sequences for backpressure, abort and mid-burst reset.
module tb_regfile_scan_reader;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  start_addr;
  logic [4:0]  count;
  logic        abort;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] out_data;
  logic [3:0]  out_addr;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  regfile_scan_reader #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .count(count), .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // bank model: reg[i] = A000_0000 + i, one-cycle read latency
  always @(posedge clk)
    if (rd_en) rd_data <= 32'hA000_0000 + 32'(rd_addr);

  typedef struct {
    logic [3:0] sa;
    logic [4:0] cnt;
    int         n;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_start(input logic [3:0] sa, input logic [4:0] cnt);
    @(negedge clk);
    start_addr = sa; count = cnt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL wait_valid: got timeout expected out_valid at %0t", $time);
    end
  endtask

  task automatic chk_word(input logic [3:0] a, input logic last);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_addr", 32'(out_addr), 32'(a));
    chk("out_data", out_data, 32'hA000_0000 + 32'(a));
    chk("out_last", 32'(out_last), 32'(last));
  endtask

  // full-rate burst with out_ready high; k counts negedges after start edge
  task automatic run_burst(input logic [3:0] sa, input logic [4:0] cnt, input int n);
    out_ready = 1'b1;
    do_start(sa, cnt);
    for (int k = 1; k <= 3*n + 2; k++) begin
      logic       exp_rd, exp_v;
      logic [3:0] a;
      int         i;
      exp_rd = (k % 3 == 1) && (k < 3*n);
      exp_v  = (k % 3 == 0) && (k <= 3*n);
      i      = k/3 - 1;
      chk("rd_en", 32'(rd_en), 32'(exp_rd));
      if (exp_rd) begin
        a = 4'(sa + 4'((k-1)/3));
        chk("rd_addr", 32'(rd_addr), 32'(a));
      end
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) begin
        a = 4'(sa + 4'(i));
        chk_word(a, i == n-1);
      end
      chk("done", 32'(done), 32'(k == 3*n + 1));
      chk("busy", 32'(busy), 32'(k <= 3*n + 1));
      @(negedge clk);
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", 32'(out_addr), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'd0,  5'd4,  4};
    vecs[1] = '{4'd14, 5'd4,  4};
    vecs[2] = '{4'd5,  5'd0,  16};
    vecs[3] = '{4'd9,  5'd20, 16};
    vecs[4] = '{4'd3,  5'd1,  1};
    vecs[5] = '{4'd15, 5'd16, 16};

    reset_n = 1'b0; start = 1'b0; start_addr = '0; count = '0;
    abort = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero();
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) run_burst(vecs[v].sa, vecs[v].cnt, vecs[v].n);

    // backpressure on word 2 of 3; start re-pulsed while busy must be ignored
    out_ready = 1'b1;
    do_start(4'd2, 5'd3);
    wait_valid();
    chk_word(4'd2, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    wait_valid();
    for (int j = 0; j < 5; j++) begin
      chk_word(4'd3, 1'b0);
      chk("stall_rd_en", 32'(rd_en), 0);
      start = 1'b1; start_addr = 4'd9; count = 5'd2;
      @(negedge clk);
    end
    start = 1'b0; out_ready = 1'b1;
    chk_word(4'd3, 1'b0);
    @(negedge clk);
    chk("bp_rd_en", 32'(rd_en), 1);
    chk("bp_rd_addr", 32'(rd_addr), 4);
    wait_valid();
    chk_word(4'd4, 1'b1);
    @(negedge clk);
    chk("bp_done", 32'(done), 1);
    @(negedge clk);
    chk("bp_busy", 32'(busy), 0);
    chk("bp_done_end", 32'(done), 0);

    // abort during SEND of word 1 of 8 with ready low
    out_ready = 1'b0;
    do_start(4'd0, 5'd8);
    wait_valid();
    chk_word(4'd0, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_valid", 32'(out_valid), 0);
    chk("ab_done", 32'(done), 1);
    chk("ab_busy", 32'(busy), 1);
    chk("ab_rd_en", 32'(rd_en), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ab_done_once", 32'(done), 0);
    chk("ab_idle", 32'(busy), 0);
    for (int j = 0; j < 4; j++) begin
      chk("ab_quiet_rd", 32'(rd_en), 0);
      chk("ab_quiet_busy", 32'(busy), 0);
      @(negedge clk);
    end
    run_burst(4'd7, 5'd2, 2);

    // asynchronous reset in CAPT
    out_ready = 1'b1;
    do_start(4'd5, 5'd4);
    chk("rs_issue", 32'(rd_en), 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_all_zero();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("rs_no_done", 32'(done), 0);
      chk("rs_busy", 32'(busy), 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    run_burst(4'd5, 5'd4, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
